// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_if
// Purpose  : Read, issue, writeback and flush bundle for regfile_scoreboard.
// Revision : 1.0
// ============================================================================
interface regfile_scoreboard_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  parameter int TAG_W = 4
);
  localparam int AW = $clog2(NREGS);

  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic [TAG_W-1:0]    issue_tag;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [TAG_W-1:0]    wb_tag;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic                busy_any;

  modport master (
    output rd_addr, issue_valid, issue_rd, issue_tag,
    output wb_valid, wb_rd, wb_tag, wb_data, flush,
    input  rd_data, rd_busy, busy_any
  );

  modport slave (
    input  rd_addr, issue_valid, issue_rd, issue_tag,
    input  wb_valid, wb_rd, wb_tag, wb_data, flush,
    output rd_data, rd_busy, busy_any
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : GPR file with NRP read ports and a tagged busy scoreboard.
//            Optional same-cycle writeback bypass: REGFILE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_scoreboard_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  w_regs [NREGS];
  logic [TAG_W-1:0] w_tags [NREGS];
  logic [NREGS-1:0] w_busy;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign w_regs[r] = '0;
      assign w_tags[r] = '0;
      assign w_busy[r] = 1'b0;
    end else begin : g_live
      logic [XLEN-1:0]  data_q, data_d;
      logic [TAG_W-1:0] tag_q, tag_d;
      logic             busy_q, busy_d;
      logic             w_wb_hit, w_iss_hit;

      assign w_wb_hit  = bus.wb_valid && (bus.wb_rd == AW'(r));
      // An issue coinciding with a flush belongs to the squashed path.
      assign w_iss_hit = bus.issue_valid && !bus.flush && (bus.issue_rd == AW'(r));

      always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (w_wb_hit) begin
          data_d = bus.wb_data;
          if (bus.wb_tag == tag_q) begin
            busy_d = 1'b0;
          end
        end
        if (w_iss_hit) begin
          busy_d = 1'b1;
          tag_d  = bus.issue_tag;
        end
        if (bus.flush) begin
          busy_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q <= '0;
          tag_q  <= '0;
          busy_q <= 1'b0;
        end else begin
          data_q <= data_d;
          tag_q  <= tag_d;
          busy_q <= busy_d;
        end
      end

      assign w_regs[r] = data_q;
      assign w_tags[r] = tag_q;
      assign w_busy[r] = busy_q;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_wb_we;
  assign w_wb_we = bus.wb_valid && (bus.wb_rd != '0);
`endif

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = bus.rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    logic w_byp, w_iss_same, w_release;
    assign w_byp      = w_wb_we && (w_addr == bus.wb_rd);
    assign w_iss_same = bus.issue_valid && (bus.issue_rd == w_addr);
    // Only a tag-matching writeback with no fresh producer retires the hazard early.
    assign w_release  = w_byp && (bus.wb_tag == w_tags[w_addr]) && !w_iss_same;
    assign bus.rd_data[k*XLEN +: XLEN] = w_byp ? bus.wb_data : w_regs[w_addr];
    assign bus.rd_busy[k]              = w_release ? 1'b0 : w_busy[w_addr];
`else
    assign bus.rd_data[k*XLEN +: XLEN] = w_regs[w_addr];
    assign bus.rd_busy[k]              = w_busy[w_addr];
`endif
  end

  assign bus.busy_any = |w_busy;

`ifndef REGFILE_BYPASS_EN
  logic w_unused;
  assign w_unused = ^{w_tags[0], bus.issue_tag[0]} & 1'b0;
`endif
endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the ysyx core, successor to the single-write-port GPR block. Adds N read ports, a per-register busy scoreboard with producer tags for RAW/WAW hazard detection, pipeline flush, and optional same-cycle writeback bypass. Sits between decode/issue (reads operands, marks destinations busy) and writeback (commits results, releases busy).

Parameters:
XLEN, 64, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2); AW = log2(NREGS) is a derived localparam
NRP, 2, number of combinational read ports
TAG_W, 4, width of the producer tag carried from issue to writeback

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
rd_addr  in  NRP*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NRP*XLEN  read data per port
rd_busy  out  NRP  1 = register at that port's address has a pending producer
issue_valid  in  1  mark issue_rd busy this cycle
issue_rd  in  AW  destination register being issued
issue_tag  in  TAG_W  producer tag of the issuing instruction
wb_valid  in  1  write wb_data to wb_rd this cycle
wb_rd  in  AW  writeback destination
wb_tag  in  TAG_W  producer tag of the writing instruction
wb_data  in  XLEN  writeback value
flush  in  1  clear every busy bit (pipeline squash)
busy_any  out  1  OR of all busy bits

Behaviour:
- Storage: NREGS x XLEN data array, NREGS busy bits, NREGS x TAG_W latest-tag array. Register 0 reads as 0, is never written, and is never busy.
- Reset (rst=1 at posedge clk): all registers 0, all busy bits 0, all tags 0. rst has priority over every other input. After reset: rd_data=0, rd_busy=0, busy_any=0.
- Read: combinational from current state, zero latency. rd_busy[k] = busy[rd_addr_k] (0 for address 0).
- Writeback (wb_valid=1, wb_rd!=0): the data array entry is updated at the next edge regardless of tag. The busy bit is cleared only if wb_tag equals the stored tag; otherwise busy stays set, because a younger producer is still outstanding (WAW).
- Issue (issue_valid=1, issue_rd!=0): at the next edge, busy[issue_rd]=1 and tag[issue_rd]=issue_tag.
- Issue and writeback to the same rd in one cycle: issue wins. Busy ends set with tag=issue_tag, and the data is still written.
- Issue and writeback to different registers in one cycle: both take effect independently.
- flush=1: all busy bits clear at the next edge, and data writes in the same cycle still occur. An issue in the same cycle as flush is dropped, so no bit is set. Tags are left unchanged.
- Writes to rd=0 and issues to rd=0 are ignored.
- busy_any is combinational from the registered busy bits.
- No handshake back-pressure: every valid input is accepted in the cycle it is asserted.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: if wb_valid=1, wb_rd!=0 and rd_addr_k==wb_rd, then rd_data[k]=wb_data in the same cycle. rd_busy[k] is forced to 0 when wb_tag matches the stored tag and no same-cycle issue targets that register; otherwise it shows the registered busy bit.
- Undefined: reads always return registered state. A register written this cycle shows its old value and busy status until the following cycle.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then rd_addr={5,0} -> rd_data={0,0}, rd_busy=00, busy_any=0.
- Issue/wb: issue rd=3 tag=2; next cycle rd_busy for x3=1, busy_any=1; wb rd=3 tag=2 data=0xDEAD_BEEF -> next cycle x3 reads 0xDEADBEEF, busy=0, busy_any=0.
- WAW: issue x7 tag=1, then issue x7 tag=2, then wb x7 tag=1 data=0x11 -> x7=0x11 and busy=1. Then wb x7 tag=2 data=0x22 -> x7=0x22 and busy=0.
- x0 and collision: issue rd=0, wb rd=0 data=0xFF -> x0 reads 0, never busy. Issue x4 tag=5 plus wb x4 tag=5 data=0x9 in the same cycle -> x4=0x9, busy=1 with tag 5.
- Flush and reset mid-operation: busy on x1, x2, x9, then flush plus issue x10 -> all busy 0, x10 not busy. Busy on x1 with x1=0x5, then assert rst during a wb -> x1=0, busy 0.
- Bypass (REGFILE_BYPASS_EN defined): x6 busy with tag 3, wb x6 tag=3 data=0xABC, rd_addr=6 in the same cycle -> rd_data=0xABC, rd_busy=0 that cycle. With the macro undefined -> old value and busy=1 that cycle, new value the next cycle.
